// File: rtl/ctx_arith_pkg.sv
// Shared types and helpers for the ctx_arith_pipe block.
// Saturating helpers are only referenced when CTX_ARITH_SAT_EN is defined.
package ctx_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        OUT  = 2'd2
    } ctx_state_t;

    // Widest operand the generic helpers support (products need 2*w bits of 64).
    localparam int MAX_W = 32;

    // Quotient reported for a zero divisor: all ones at any width up to MAX_W.
    localparam logic [MAX_W-1:0] DZ_QUOT = '1;

    // Largest unsigned value representable in w bits.
    function automatic logic [63:0] max_of(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Unsigned add clamped to w bits.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
        logic [63:0] s;
        s = a + b;
        return (s > max_of(w)) ? max_of(w) : s;
    endfunction

    // Unsigned subtract clamped at zero.
    function automatic logic [63:0] sat_sub(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
        logic [63:0] d;
        d = (a > b) ? (a - b) : 64'd0;
        return (d > max_of(w)) ? max_of(w) : d;
    endfunction

    // Unsigned multiply clamped to w bits (operands must fit in MAX_W bits).
    function automatic logic [63:0] sat_mul(input logic [63:0] a, input logic [63:0] b,
                                            input int w);
        logic [63:0] p;
        p = a * b;
        return (p > max_of(w)) ? max_of(w) : p;
    endfunction

endpackage

// File: rtl/ctx_serial_div.sv
// Restoring serial divider: one quotient bit per cycle, W cycles after start.
// done_o is high during the final step and quotient_o carries that step's
// result combinationally, so the caller can consume it on the same edge.
module ctx_serial_div
    import ctx_arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quotient_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [W:0]    shifted;
    logic          ge;
    logic [W-1:0]  rem_step, quo_step;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted  = {rem_q, quo_q[W-1]};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_step = W'(ge ? (shifted - {1'b0, dvs_q}) : shifted);
        quo_step = {quo_q[W-2:0], ge};
    end

    // Load on start, then iterate until the step counter runs out.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CW'(1));
    // The restoring loop already yields all ones for a zero divisor; force it
    // anyway so the convention does not hinge on the step arithmetic.
    assign quotient_o = (dvs_q == '0) ? DZ_QUOT[W-1:0] : quo_step;

endmodule

// File: rtl/ctx_arith_pipe.sv
// Clocked difference / quotient-accumulate / product context unit.
// Per operand pair: C = A-B, D += A/B, XOUT = C + (A*B)[W-1:0].
// Define CTX_ARITH_SAT_EN for saturating arithmetic instead of modular wrap.
module ctx_arith_pipe
    import ctx_arith_pkg::*;
#(
    parameter int W      = 8,
    parameter int DACC_W = W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [W-1:0]      a_i,
    input  logic [W-1:0]      b_i,
    input  logic              clr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [W-1:0]      xout_o,
    output logic [W-1:0]      c_out_o,
    output logic [DACC_W-1:0] d_out_o,
    output logic              dz_o
);

    ctx_state_t        state_q, state_d;
    logic              init_q;
    logic              start_q, start_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d, c_q, c_d, xout_q, xout_d;
    logic              dz_q, dz_d;
    logic [DACC_W-1:0] acc_q, acc_d, dout_q, dout_d;

    logic              div_busy, div_done;
    logic [W-1:0]      quot;
    logic [W-1:0]      c_new, x_new;
    logic [DACC_W-1:0] acc_base, acc_next;

    ctx_serial_div #(.W(W)) u_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_q),
        .dividend_i (a_q),
        .divisor_i  (b_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quot)
    );

    // Result arithmetic: C from the live operands at transfer, XOUT and the
    // accumulator from the latched operands at the end of the division.
    always_comb begin
        acc_base = clr_i ? '0 : acc_q;
`ifdef CTX_ARITH_SAT_EN
        c_new    = W'(sat_sub(64'(a_i), 64'(b_i), W));
        x_new    = W'(sat_add(64'(c_q), sat_mul(64'(a_q), 64'(b_q), W), W));
        acc_next = DACC_W'(sat_add(64'(acc_base), 64'(quot), DACC_W));
`else
        c_new    = a_i - b_i;
        x_new    = c_q + a_q * b_q;
        acc_next = acc_base + DACC_W'(quot);
`endif
    end

    // FSM next state plus operand/result register updates.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        xout_d  = xout_q;
        dz_d    = dz_q;
        dout_d  = dout_q;
        // Clear only touches the live accumulator, never the held D_OUT.
        acc_d   = clr_i ? '0 : acc_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    c_d     = c_new;
                    start_d = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (div_busy && div_done) begin
                    acc_d   = acc_next;
                    dout_d  = acc_next;
                    xout_d  = x_new;
                    dz_d    = (b_q == '0);
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            xout_q  <= '0;
            dz_q    <= 1'b0;
            acc_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            xout_q  <= xout_d;
            dz_q    <= dz_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
        end
    end

    // Ready waits one clock after reset release so IN_READY is low in reset.
    assign in_ready_o  = (state_q == IDLE) && init_q;
    assign out_valid_o = (state_q == OUT);
    assign xout_o      = xout_q;
    assign c_out_o     = c_q;
    assign d_out_o     = dout_q;
    assign dz_o        = dz_q;

endmodule

// File: tb/tb_ctx_arith_pipe.sv
// Self-checking bench for ctx_arith_pipe (W=8, DACC_W=8), randomized against a
// plain-arithmetic model; honours CTX_ARITH_SAT_EN like the design.
module tb_ctx_arith_pipe;

    localparam int W      = 8;
    localparam int DACC_W = 8;
    localparam int MASK   = (1 << W) - 1;
    localparam int DMASK  = (1 << DACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      a = '0;
    logic [W-1:0]      b = '0;
    logic              clr = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W-1:0]      xout;
    logic [W-1:0]      c_out;
    logic [DACC_W-1:0] d_out;
    logic              dz;

    int checks = 0;
    int errors = 0;
    int m_d    = 0;   // model accumulator

    always #5 clk = ~clk;

    ctx_arith_pipe #(.W(W), .DACC_W(DACC_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .clr_i       (clr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .xout_o      (xout),
        .c_out_o     (c_out),
        .d_out_o     (d_out),
        .dz_o        (dz)
    );

    // ---------------- reference model ----------------
    function automatic int m_q(input int av, input int bv);
        return (bv == 0) ? MASK : av / bv;
    endfunction

    function automatic int m_c(input int av, input int bv);
`ifdef CTX_ARITH_SAT_EN
        return (av >= bv) ? av - bv : 0;
`else
        return (av - bv) & MASK;
`endif
    endfunction

    function automatic int m_x(input int av, input int bv);
`ifdef CTX_ARITH_SAT_EN
        int p, s;
        p = (av * bv > MASK) ? MASK : av * bv;
        s = m_c(av, bv) + p;
        return (s > MASK) ? MASK : s;
`else
        return (m_c(av, bv) + av * bv) & MASK;
`endif
    endfunction

    function automatic int m_acc(input int d, input int q);
`ifdef CTX_ARITH_SAT_EN
        return (d + q > DMASK) ? DMASK : d + q;
`else
        return (d + q) & DMASK;
`endif
    endfunction

    // Advance the model accumulator for one operation; clr_at in 0..W lands
    // inside the division (at W: on the accumulate edge), so clear-then-add.
    function automatic void m_step(input int av, input int bv, input int clr_at);
        if (clr_at >= 0 && clr_at <= W) m_d = 0;
        m_d = m_acc(m_d, m_q(av, bv));
    endfunction

    // ---------------- drivers ----------------
    // Transfer one pair and wait for OUT_VALID. lat counts clocks from the
    // transfer edge; CLR is raised for the cycle following clock lat==clr_at.
    task automatic run_op(input int av, input int bv, input int clr_at, output int lat,
                          output int xo, output int co, output int dov, output int dzo);
        int waits;
        waits = 0;
        lat   = 0;
        @(negedge clk);
        a = W'(av);
        b = W'(bv);
        in_valid = 1'b1;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        while (!out_valid && lat < 40) begin
            if (lat == clr_at) clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
            lat++;
        end
        xo  = int'(xout);
        co  = int'(c_out);
        dov = int'(d_out);
        dzo = int'(dz);
    endtask

    task automatic pop(input int dly);
        repeat (dly) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || xout !== '0 || c_out !== '0 ||
            d_out !== '0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b x=%0d c=%0d d=%0d dz=%b, required all 0",
                     in_ready, out_valid, xout, c_out, d_out, dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b, required rdy=1 vld=0", in_ready, out_valid);
        end
        m_d = 0;
    endtask

    // Directed pairs followed by random ones, each checked field by field.
    task automatic test_arith(input int n_rand);
        int qa[$], qb[$];
        int lat, xo, co, dov, dzo, av, bv;
        qa = '{20, 3, 200, 7, 4, 255, 0, 255};
        qb = '{3, 5, 2, 0, 2, 1, 9, 255};
        for (int i = 0; i < n_rand; i++) begin
            qa.push_back($urandom_range(0, MASK));
            qb.push_back(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, MASK));
        end
        for (int i = 0; i < qa.size(); i++) begin
            av = qa[i];
            bv = qb[i];
            run_op(av, bv, -1, lat, xo, co, dov, dzo);
            m_step(av, bv, -1);
            checks++;
            if (lat !== W + 1) begin
                errors++;
                $display("FAIL latency A=%0d B=%0d: got %0d required %0d", av, bv, lat, W + 1);
            end
            checks++;
            if (co !== m_c(av, bv)) begin
                errors++;
                $display("FAIL c_out A=%0d B=%0d: got %0d required %0d", av, bv, co, m_c(av, bv));
            end
            checks++;
            if (xo !== m_x(av, bv)) begin
                errors++;
                $display("FAIL xout A=%0d B=%0d: got %0d required %0d", av, bv, xo, m_x(av, bv));
            end
            checks++;
            if (dov !== m_d) begin
                errors++;
                $display("FAIL d_out A=%0d B=%0d: got %0d required %0d", av, bv, dov, m_d);
            end
            checks++;
            if (dzo !== int'(bv == 0)) begin
                errors++;
                $display("FAIL dz A=%0d B=%0d: got %0d required %0d", av, bv, dzo, bv == 0);
            end
            pop($urandom_range(0, 3));
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL pop_idle: rdy=%b vld=%b, required rdy=1 vld=0", in_ready, out_valid);
            end
        end
    endtask

    // Divide-by-zero accumulate from a cleared accumulator, then 4/2.
    task automatic test_dz();
        int lat, xo, co, dov, dzo, exp_final;
`ifdef CTX_ARITH_SAT_EN
        exp_final = 255;
`else
        exp_final = 1;
`endif
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_d = 0;
        run_op(7, 0, -1, lat, xo, co, dov, dzo);
        m_step(7, 0, -1);
        pop(0);
        checks++;
        if (dov !== 255 || dzo !== 1) begin
            errors++;
            $display("FAIL dz_first: d=%0d dz=%0d, required d=255 dz=1", dov, dzo);
        end
        run_op(4, 2, -1, lat, xo, co, dov, dzo);
        m_step(4, 2, -1);
        pop(0);
        checks++;
        if (dov !== exp_final || dzo !== 0) begin
            errors++;
            $display("FAIL dz_follow: d=%0d dz=%0d, required d=%0d dz=0", dov, dzo, exp_final);
        end
    endtask

    // Held result: stable outputs, ignored IN_VALID and a CLR that must not
    // disturb D_OUT; the next operation then starts from a cleared D.
    task automatic test_hold();
        int lat, xo, co, dov, dzo;
        run_op(150, 7, -1, lat, xo, co, dov, dzo);
        m_step(150, 7, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            clr = (i == 2);
            @(posedge clk);
            #1;
            clr = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(xout) !== xo ||
                int'(c_out) !== co || int'(d_out) !== dov || int'(dz) !== dzo) begin
                errors++;
                $display("FAIL hold cyc %0d: vld=%b rdy=%b x=%0d c=%0d d=%0d dz=%b, required 1 0 %0d %0d %0d %0d",
                         i, out_valid, in_ready, xout, c_out, d_out, dz, xo, co, dov, dzo);
            end
        end
        m_d = 0;
        in_valid = 1'b0;
        pop(0);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: rdy=%b vld=%b, required rdy=1 vld=0", in_ready, out_valid);
        end
        run_op(9, 3, -1, lat, xo, co, dov, dzo);
        m_step(9, 3, -1);
        pop(0);
        checks++;
        if (dov !== m_d) begin
            errors++;
            $display("FAIL hold_clr_d: got %0d required %0d", dov, m_d);
        end
    endtask

    // CLR on the accumulate edge and in the middle of the division.
    task automatic test_clr();
        int lat, xo, co, dov, dzo;
        run_op(90, 1, -1, lat, xo, co, dov, dzo);
        m_step(90, 1, -1);
        pop(0);
        run_op(50, 7, W, lat, xo, co, dov, dzo);
        m_step(50, 7, W);
        pop(0);
        checks++;
        if (dov !== 7 || lat !== W + 1) begin
            errors++;
            $display("FAIL clr_acc_edge: d=%0d lat=%0d, required d=7 lat=%0d", dov, lat, W + 1);
        end
        run_op(100, 4, 3, lat, xo, co, dov, dzo);
        m_step(100, 4, 3);
        pop(1);
        checks++;
        if (dov !== m_d || co !== m_c(100, 4) || lat !== W + 1) begin
            errors++;
            $display("FAIL clr_mid_div: d=%0d c=%0d lat=%0d, required d=%0d c=%0d lat=%0d",
                     dov, co, lat, m_d, m_c(100, 4), W + 1);
        end
    endtask

    // Asynchronous reset in the middle of a division.
    task automatic test_reset_mid_div();
        int lat, xo, co, dov, dzo;
        @(negedge clk);
        a = 8'd60;
        b = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || xout !== '0 || c_out !== '0 ||
            d_out !== '0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div: rdy=%b vld=%b x=%0d c=%0d d=%0d dz=%b, required all 0",
                     in_ready, out_valid, xout, c_out, d_out, dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: rdy=%b vld=%b, required rdy=1 vld=0", in_ready, out_valid);
        end
        m_d = 0;
        run_op(33, 4, -1, lat, xo, co, dov, dzo);
        m_step(33, 4, -1);
        pop(0);
        checks++;
        if (dov !== m_d || lat !== W + 1) begin
            errors++;
            $display("FAIL after_reset_op: d=%0d lat=%0d, required d=%0d lat=%0d", dov, lat, m_d, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_arith(16);
        test_dz();
        test_hold();
        test_clr();
        test_reset_mid_div();
        test_arith(8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
